// File: rtl/regfile_wb_if.sv
// regfile_wb_if: writeback bus between the writeback sources and the
// register-file write-port controller.
//
//   req_valid  [NREQ]       requester i has a write pending
//   req_rd     [NREQ*5]     destination of requester i at [5i+4:5i]
//   req_data   [NREQ*XLEN]  data of requester i at [XLEN*i+XLEN-1:XLEN*i]
//   req_ready  [NREQ]       one-hot grant; transfer when valid & ready
//   RegWrite                register-file write enable (registered)
//   rd         [5]          register-file write address (registered)
//   write_data [XLEN]       register-file write data (registered)
//
// master: the requester side (drives requests, sees grant and write port).
// slave:  the arbiter (accepts requests, drives grant and write port).
interface regfile_wb_if #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 RegWrite;
    logic [4:0]           rd;
    logic [XLEN-1:0]      write_data;

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, RegWrite, rd, write_data
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, RegWrite, rd, write_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-port controller for the 32 x 32-bit register
// file. Round-robin arbitration of up to NREQ writeback sources onto the
// single write port, with a registered winning write.
//
// Optional feature macro: REGFILE_SCOREBOARD_EN
//   defined   - 32-bit pending-write scoreboard drives hazard for decode
//   undefined - no pending storage; hazard tied 0; issue/check inputs ignored
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   wb           slave modport of regfile_wb_if (requests, grant, write port)
//   issue_valid  in   decode issued an instruction writing issue_rd
//   issue_rd     in   destination of the issued instruction
//   chk_rs1/2    in   source registers checked by decode
//   hazard       out  combinational: a checked source has a write in flight
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic        clock,
    input  logic        reset,
    regfile_wb_if.slave wb,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        hazard
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   grant_idx;
    logic [NREQ-1:0] grant;
    logic            fire;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            regwrite_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] data_q;

    // Round-robin search: first valid requester at ptr, ptr+1, ... mod NREQ.
    always_comb begin
        int cand;
        // NOTE: every output of this block gets a default before the search
        // loop, so no path leaves a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        fire      = 1'b0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!fire && wb.req_valid[cand]) begin
                fire        = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    // The grant is the ready; it is forced low while reset is held so no
    // requester believes a transfer happened that the flops will discard.
    assign wb.req_ready = reset ? '0 : grant;

    assign sel_rd   = wb.req_rd[5*int'(grant_idx) +: 5];
    assign sel_data = wb.req_data[XLEN*int'(grant_idx) +: XLEN];
    assign ptr_nxt  = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;

    // NOTE: the output register and pointer are plain flops (not a RAM), so
    // they all take the asynchronous reset and clear the instant reset rises.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
        end else if (fire) begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values regardless of statement order.
            ptr        <= ptr_nxt;
            regwrite_q <= (sel_rd != 5'd0); // rd 0 consumes the grant but is dropped
            rd_q       <= sel_rd;
            data_q     <= sel_data;
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    assign wb.RegWrite   = regwrite_q;
    assign wb.rd         = rd_q;
    assign wb.write_data = data_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    // Clear for the write landing this edge first, then set for the new
    // issue, so a same-edge set and clear of one index leaves it pending.
    always_comb begin
        pending_nxt = pending;
        if (regwrite_q) begin
            pending_nxt[rd_q] = 1'b0;
        end
        if (issue_valid && issue_rd != 5'd0) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Reads only the registered vector: an issue in this cycle is not
    // visible to the check until the following cycle.
    assign hazard = ((chk_rs1 != 5'd0) && pending[chk_rs1]) ||
                    ((chk_rs2 != 5'd0) && pending[chk_rs2]);
`else
    logic unused_scoreboard_inputs;
    assign unused_scoreboard_inputs = ^{issue_valid, issue_rd, chk_rs1, chk_rs2};
    assign hazard = 1'b0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32 x 32-bit register file. Arbitrates up to NREQ writeback sources (ALU, load unit, mul/div) onto the single register-file write port with round-robin fairness and valid/ready handshakes, and registers the winning write. Optionally keeps a pending-write scoreboard so decode can stall on RAW hazards. Sits between the execute/memory units and the register file.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a write pending
- req_rd  in  NREQ*5  destination of requester i at [5i+4:5i]
- req_data  in  NREQ*XLEN  data of requester i at [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- RegWrite  out  1  register-file write enable (registered)
- rd  out  5  register-file write address (registered)
- write_data  out  XLEN  register-file write data (registered)
- issue_valid  in  1  decode issued an instruction writing issue_rd
- issue_rd  in  5  destination of issued instruction
- chk_rs1, chk_rs2  in  5 each  sources checked by decode
- hazard  out  1  combinational: a checked source has a write in flight

## Operation
- Round-robin pointer ptr (0..NREQ-1). Grant = first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
- req_ready is combinational, at most one bit high, only for a valid requester; all zero while reset is asserted.
- On transfer from i: output register loads RegWrite = (req_rd_i != 0), rd = req_rd_i, write_data = req_data_i; ptr <- (i+1) mod NREQ.
- No transfer: RegWrite <- 0; rd and write_data hold; ptr holds.
- rd = 0 requests are accepted and consume the grant, but produce RegWrite = 0 (write dropped).
- Requester must hold req_valid, req_rd, req_data stable until transfer; ungranted requests wait indefinitely; round-robin bounds wait to NREQ-1 grants.
- Scoreboard (see Configuration): 32-bit pending vector, bit 0 constant 0.
  - Set: issue_valid & issue_rd != 0 sets pending[issue_rd] at the edge.
  - Clear: edge where RegWrite = 1 clears pending[rd] (write lands in the register file on that same edge).
  - Same-edge set and clear of the same index: set wins.
  - hazard = (chk_rs1 != 0 & pending[chk_rs1]) | (chk_rs2 != 0 & pending[chk_rs2]); reads the registered vector only (no forwarding of same-cycle issue).
  - One bit per register: issuing a second producer to an already-pending rd is a protocol violation; bench asserts it never occurs.

## Timing
- Reset values: RegWrite 0, rd 0, write_data 0, ptr 0, pending all 0, hazard 0, req_ready all 0.
- Reset asserted mid-operation: outputs and state clear immediately (async); a transfer in that cycle is lost; requesters re-present after release.
- Latency: transfer at edge E -> RegWrite high during cycle E..E+1 -> register-file write at edge E+1 -> readable from cycle after E+1.
- Throughput: one write per cycle; back-to-back transfers from different requesters allowed.
- hazard: issue at edge E0 -> hazard visible from cycle after E0 until edge E+1 (write commit), inclusive of the cycle RegWrite is high.

## Configuration
- REGFILE_SCOREBOARD_EN defined: pending vector and hazard logic as above.
- Undefined: no pending storage; hazard tied 0; issue_valid, issue_rd, chk_rs1, chk_rs2 ignored; arbitration unchanged.

## Test plan
- Reset: assert reset with all req_valid = 1 -> req_ready = 000, RegWrite = 0, rd = 0, hazard = 0; release -> requester 0 granted first.
- Round-robin: req_valid = 111 held for 6 cycles, rd = 1/2/3 -> grant order 0,1,2,0,1,2; RegWrite pulses each cycle with rd 1,2,3,1,2,3 one cycle after each grant.
- Single requester: only req 2 valid, rd = 7, data = 0xDEADBEEF -> req_ready = 100 same cycle; next cycle RegWrite = 1, rd = 7, write_data = 0xDEADBEEF; following cycle RegWrite = 0.
- rd = 0: req 1 valid, rd = 0, data = 0x1234 -> req_ready[1] = 1, RegWrite stays 0, ptr advances to 2.
- Scoreboard (macro defined): issue rd = 5; chk_rs1 = 5 -> hazard = 1 until the edge RegWrite = 1 with rd = 5 commits, then 0; same-edge issue rd = 5 and commit rd = 5 -> pending[5] stays 1; chk_rs1 = chk_rs2 = 0 -> hazard = 0 always.
- Macro undefined: same issue/check sequence -> hazard = 0 throughout; arbitration results identical to defined build.
